// File: rtl/rr_mux_n.sv
// rr_mux_n: N-channel, WIDTH-bit arbitrated multiplexer with a registered
// output stage. Producers present words with valid/ready; a round-robin or
// fixed-priority arbiter chooses one per cycle. The chosen word is captured
// into a single output register that the consumer drains with valid/ready.
//
// Handshake semantics (both sides): a word moves on a clock edge exactly when
// valid and ready are both high in the cycle before that edge. A producer may
// drop valid before it is granted. in_ready never depends on in_data. Once
// out_valid is high, out_data/out_sel stay stable until out_ready is seen.
//
// Timing paths: in_* reach out_* only through the output register. out_ready
// reaches in_ready combinationally, which lets a draining register reload in
// the same cycle and keeps one word per cycle with out_ready tied high.

module rr_mux_n #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int MODE  = 0,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  // Round-robin pointer: the channel searched first on the next arbitration.
  // In fixed-priority mode it is never advanced and stays at zero.
  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  ptr_next;

  // Arbiter result: grant_any says someone won, grant_idx names the winner,
  // grant is the same decision as a one-hot vector.
  logic             grant_any;
  logic [SELW-1:0]  grant_idx;
  logic [N-1:0]     grant;

  // Word of the winning channel, and the qualified load condition.
  logic [WIDTH-1:0] grant_data;
  logic             load_en;
  logic             take;

  // The output register can accept a new word when empty or when draining.
  assign load_en = !out_valid || out_ready;

  // Arbitration: search channels in priority order and keep the first valid.
  // Loops run from the lowest-priority slot upward so the last hit, which is
  // the highest-priority valid channel, is the one that sticks.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (MODE == 1) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant_any = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (in_valid[SELW'(idx)]) begin
          grant_any = 1'b1;
          grant_idx = SELW'(idx);
        end
      end
    end
  end

  // Expand the winner index into a one-hot grant vector (zero when idle).
  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_any && (grant_idx == SELW'(i))) grant[i] = 1'b1;
    end
  end

  // Select the winning channel's word; AND-OR mux keyed by the one-hot grant.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_data = grant_data | in_data[i*WIDTH +: WIDTH];
    end
  end

  // Pointer moves to the channel after the winner, wrapping N-1 back to 0.
  always_comb begin
    if (MODE != 0) begin
      ptr_next = '0;
    end else if (grant_idx == SELW'(N - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant_idx + SELW'(1);
    end
  end

  // Ready goes to the granted channel only when the register can take a word;
  // reset forces every ready low so nothing is consumed during reset.
  assign in_ready = (load_en && !reset) ? grant : '0;

  // An accepted transfer: a grant always implies the channel is valid.
  assign take = load_en && grant_any;

  // Output register and arbitration pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_sel   <= grant_idx;
      ptr       <= ptr_next;
    end else if (load_en) begin
      out_valid <= 1'b0;
    end
  end

  // At most one producer may be told its word was taken in any cycle.
  always @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(in_ready));
    end
  end

endmodule
